pgm_rd: RTL and testbench

PGM_RD -- requirements
Module: pgm_rd

---
 rtl/pgm_rd.sv | 216 +++++++++++++++++++++
 tb/tb_pgm_rd.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_rd.sv
// Read stage of the packet generator: forwards upstream packets unchanged, or replays
// the packet image held in the 128-entry packet RAM as a stream of generated packets.
module pgm_rd #(
  parameter             PLATFORM = "Xilinx",
  parameter logic [7:0] LMID     = 8'd63,
  parameter logic [7:0] DMID     = 8'd6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1023:0] in_rd_phv,
  input  logic          in_rd_phv_wr,
  output logic          out_rd_phv_alf,
  input  logic [133:0]  in_rd_data,
  input  logic          in_rd_data_wr,
  input  logic          in_rd_valid,
  input  logic          in_rd_valid_wr,
  output logic          out_rd_alf,
  input  logic          pgm_bypass_flag,
  input  logic          pgm_sent_start_flag,
  input  logic          pgm_sent_finish_flag,
  output logic          rd2ram_rd_en,
  output logic [6:0]    rd2ram_addr,
  input  logic [143:0]  ram2rd_rdata,
  output logic [1023:0] out_rd_phv,
  output logic          out_rd_phv_wr,
  output logic [133:0]  out_rd_data,
  output logic          out_rd_data_wr,
  output logic          out_rd_valid,
  output logic          out_rd_valid_wr,
  input  logic          in_rd_phv_alf,
  input  logic          in_rd_alf,
  output logic [31:0]   pkt_gen_cnt,
  output logic [31:0]   pkt_drop_cnt
);

  typedef enum logic [2:0] {StIdle, StPass, StGenRd, StGenGap, StFlush} state_e;

  state_e          r_state, w_state_nxt;
  logic            r_rd_en, w_rd_en_nxt;
  logic [6:0]      r_addr, w_addr_nxt;
  logic            r_ret_vld, w_ret_vld_nxt;
  logic            r_ret_last, w_ret_last_nxt;
  logic            r_first, w_first_nxt;
  logic            r_fin, w_fin_nxt;
  logic            r_flush, w_flush_nxt;
  logic [1023:0]   r_phv, w_phv_nxt;
  logic            r_phv_wr, w_phv_wr_nxt;
  logic [133:0]    r_data, w_data_nxt;
  logic            r_data_wr, w_data_wr_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_valid_wr, w_valid_wr_nxt;
  logic [31:0]     r_gen_cnt, r_drop_cnt;

  logic            w_in_head, w_in_tail, w_gen_go, w_ret_tail, w_drop, w_flush_pend;
  logic            w_fwd, w_gen_inc;
  logic [133:0]    w_ret_beat;
  logic            w_unused;

  assign w_unused = ^{ram2rd_rdata[143:134], LMID, DMID, (PLATFORM == "Xilinx")};

  assign out_rd_phv_alf  = in_rd_phv_alf;
  assign out_rd_alf      = in_rd_alf;
  assign rd2ram_rd_en    = r_rd_en;
  assign rd2ram_addr     = r_addr;
  assign out_rd_phv      = r_phv;
  assign out_rd_phv_wr   = r_phv_wr;
  assign out_rd_data     = r_data;
  assign out_rd_data_wr  = r_data_wr;
  assign out_rd_valid    = r_valid;
  assign out_rd_valid_wr = r_valid_wr;
  assign pkt_gen_cnt     = r_gen_cnt;
  assign pkt_drop_cnt    = r_drop_cnt;

  assign w_in_head  = in_rd_data_wr && (in_rd_data[133:132] == 2'b01);
  assign w_in_tail  = in_rd_data_wr && (in_rd_data[133:132] == 2'b10);
  assign w_gen_go   = !pgm_bypass_flag && pgm_sent_start_flag && !pgm_sent_finish_flag &&
                      !in_rd_alf;
  // The beat read from address 127 always closes the packet so the address never wraps.
  assign w_ret_tail = r_ret_vld && ((ram2rd_rdata[133:132] == 2'b10) || r_ret_last);
  assign w_ret_beat = {(r_ret_last ? 2'b10 : ram2rd_rdata[133:132]), ram2rd_rdata[131:0]};
  assign w_drop     = in_rd_data_wr && ((r_state == StGenRd) || (r_state == StGenGap));
  assign w_flush_pend = w_drop ? !w_in_tail : r_flush;

  always_comb begin
    w_state_nxt    = r_state;
    w_rd_en_nxt    = 1'b0;
    w_addr_nxt     = 7'd0;
    w_ret_vld_nxt  = 1'b0;
    w_ret_last_nxt = 1'b0;
    w_first_nxt    = r_first;
    w_fin_nxt      = r_fin;
    w_flush_nxt    = w_flush_pend;
    w_phv_nxt      = '0;
    w_phv_wr_nxt   = 1'b0;
    w_data_nxt     = '0;
    w_data_wr_nxt  = 1'b0;
    w_valid_nxt    = 1'b0;
    w_valid_wr_nxt = 1'b0;
    w_fwd          = 1'b0;
    w_gen_inc      = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_fin_nxt   = 1'b0;
        w_flush_nxt = 1'b0;
        if (w_gen_go) begin
          w_state_nxt = StGenRd;
          w_rd_en_nxt = 1'b1;
          w_first_nxt = 1'b1;
        end else if (w_in_head && (pgm_bypass_flag || !pgm_sent_start_flag)) begin
          w_fwd       = 1'b1;
          w_state_nxt = StPass;
        end
      end
      StPass: begin
        w_fwd = 1'b1;
        if (w_in_tail) begin
          if (w_gen_go) begin
            w_state_nxt = StGenRd;
            w_rd_en_nxt = 1'b1;
            w_first_nxt = 1'b1;
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      StGenRd: begin
        if (pgm_sent_finish_flag) w_fin_nxt = 1'b1;
        if (r_ret_vld) begin
          w_data_nxt     = w_ret_beat;
          w_data_wr_nxt  = 1'b1;
          w_valid_nxt    = 1'b1;
          w_valid_wr_nxt = w_ret_tail;
          w_phv_wr_nxt   = r_first;
          w_first_nxt    = 1'b0;
        end
        if (r_rd_en && !w_ret_tail && (r_addr != 7'd127)) begin
          w_rd_en_nxt = 1'b1;
          w_addr_nxt  = r_addr + 7'd1;
        end
        // Once the tail is back, the single read already in flight is an overshoot.
        w_ret_vld_nxt  = r_rd_en && !w_ret_tail;
        w_ret_last_nxt = r_rd_en && (r_addr == 7'd127);
        if (w_ret_tail) begin
          w_gen_inc   = 1'b1;
          w_state_nxt = StGenGap;
        end
      end
      StGenGap: begin
        if (pgm_sent_finish_flag) w_fin_nxt = 1'b1;
        if (w_flush_pend) begin
          w_state_nxt = StFlush;
        end else if (r_fin || pgm_sent_finish_flag) begin
          w_state_nxt = StIdle;
        end else if (!in_rd_alf) begin
          w_state_nxt = StGenRd;
          w_rd_en_nxt = 1'b1;
          w_first_nxt = 1'b1;
        end
      end
      StFlush: begin
        w_flush_nxt = 1'b0;
        if (w_in_tail) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_fwd) begin
      w_phv_nxt      = in_rd_phv_wr ? in_rd_phv : '0;
      w_phv_wr_nxt   = in_rd_phv_wr;
      w_data_nxt     = in_rd_data_wr ? in_rd_data : '0;
      w_data_wr_nxt  = in_rd_data_wr;
      w_valid_nxt    = in_rd_valid;
      w_valid_wr_nxt = in_rd_valid_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_rd_en    <= 1'b0;
      r_addr     <= 7'd0;
      r_ret_vld  <= 1'b0;
      r_ret_last <= 1'b0;
      r_first    <= 1'b0;
      r_fin      <= 1'b0;
      r_flush    <= 1'b0;
      r_phv      <= '0;
      r_phv_wr   <= 1'b0;
      r_data     <= '0;
      r_data_wr  <= 1'b0;
      r_valid    <= 1'b0;
      r_valid_wr <= 1'b0;
      r_gen_cnt  <= 32'd0;
      r_drop_cnt <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_addr     <= w_addr_nxt;
      r_ret_vld  <= w_ret_vld_nxt;
      r_ret_last <= w_ret_last_nxt;
      r_first    <= w_first_nxt;
      r_fin      <= w_fin_nxt;
      r_flush    <= w_flush_nxt;
      r_phv      <= w_phv_nxt;
      r_phv_wr   <= w_phv_wr_nxt;
      r_data     <= w_data_nxt;
      r_data_wr  <= w_data_wr_nxt;
      r_valid    <= w_valid_nxt;
      r_valid_wr <= w_valid_wr_nxt;
      if (w_gen_inc && (r_gen_cnt != 32'hFFFF_FFFF)) r_gen_cnt <= r_gen_cnt + 32'd1;
      if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF)) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pgm_rd.sv
// Directed bench for pgm_rd: pass-through, RAM replay, wrap guard, backpressure, drops, reset.
module tb_pgm_rd;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1023:0] in_rd_phv;
  logic          in_rd_phv_wr;
  logic          out_rd_phv_alf;
  logic [133:0]  in_rd_data;
  logic          in_rd_data_wr, in_rd_valid, in_rd_valid_wr;
  logic          out_rd_alf;
  logic          pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag;
  logic          rd2ram_rd_en;
  logic [6:0]    rd2ram_addr;
  logic [143:0]  ram2rd_rdata;
  logic [1023:0] out_rd_phv;
  logic          out_rd_phv_wr;
  logic [133:0]  out_rd_data;
  logic          out_rd_data_wr, out_rd_valid, out_rd_valid_wr;
  logic          in_rd_phv_alf, in_rd_alf;
  logic [31:0]   pkt_gen_cnt, pkt_drop_cnt;

  logic [133:0]  mem [128];
  int            comps = 0;
  int            fails = 0;

  pgm_rd dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_rd_phv            (in_rd_phv),
    .in_rd_phv_wr         (in_rd_phv_wr),
    .out_rd_phv_alf       (out_rd_phv_alf),
    .in_rd_data           (in_rd_data),
    .in_rd_data_wr        (in_rd_data_wr),
    .in_rd_valid          (in_rd_valid),
    .in_rd_valid_wr       (in_rd_valid_wr),
    .out_rd_alf           (out_rd_alf),
    .pgm_bypass_flag      (pgm_bypass_flag),
    .pgm_sent_start_flag  (pgm_sent_start_flag),
    .pgm_sent_finish_flag (pgm_sent_finish_flag),
    .rd2ram_rd_en         (rd2ram_rd_en),
    .rd2ram_addr          (rd2ram_addr),
    .ram2rd_rdata         (ram2rd_rdata),
    .out_rd_phv           (out_rd_phv),
    .out_rd_phv_wr        (out_rd_phv_wr),
    .out_rd_data          (out_rd_data),
    .out_rd_data_wr       (out_rd_data_wr),
    .out_rd_valid         (out_rd_valid),
    .out_rd_valid_wr      (out_rd_valid_wr),
    .in_rd_phv_alf        (in_rd_phv_alf),
    .in_rd_alf            (in_rd_alf),
    .pkt_gen_cnt          (pkt_gen_cnt),
    .pkt_drop_cnt         (pkt_drop_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency; junk with a tail header when not reading.
  always @(posedge clk) begin
    if (rd2ram_rd_en) ram2rd_rdata <= {10'h0, mem[rd2ram_addr]};
    else              ram2rd_rdata <= {72{2'b10}};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [133:0] mk(input logic [1:0] h, input logic [31:0] v);
    return {h, 100'd0, v};
  endfunction

  task automatic drive_up(input logic wr, input logic [133:0] d, input logic pw,
                          input logic [1023:0] p);
    in_rd_data_wr  = wr;
    in_rd_data     = d;
    in_rd_valid    = wr;
    in_rd_valid_wr = wr && (d[133:132] == 2'b10);
    in_rd_phv_wr   = pw;
    in_rd_phv      = p;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive_up(1'b0, '0, 1'b0, '0);
    pgm_bypass_flag = 1'b0; pgm_sent_start_flag = 1'b0; pgm_sent_finish_flag = 1'b0;
    in_rd_alf = 1'b0; in_rd_phv_alf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_pkt4();
    for (int i = 0; i < 128; i++) mem[i] = mk(2'b11, 32'hE000 + 32'(i));
    mem[0] = mk(2'b01, 32'hA0);
    mem[1] = mk(2'b11, 32'hA1);
    mem[2] = mk(2'b11, 32'hA2);
    mem[3] = mk(2'b10, 32'hA3);
  endtask

  task automatic test_reset();
    apply_reset();
    comps++;
    if ({rd2ram_rd_en, rd2ram_addr, out_rd_phv_wr, out_rd_data_wr, out_rd_valid,
         out_rd_valid_wr} !== 12'd0) begin
      fails++; $display("FAIL reset_strobes got %b exp 0", {rd2ram_rd_en, rd2ram_addr,
                        out_rd_phv_wr, out_rd_data_wr, out_rd_valid, out_rd_valid_wr});
    end
    comps++;
    if (out_rd_data !== '0 || out_rd_phv !== '0) begin
      fails++; $display("FAIL reset_data got %h / %h exp 0", out_rd_data, out_rd_phv[31:0]);
    end
    comps++;
    if (pkt_gen_cnt !== 32'd0 || pkt_drop_cnt !== 32'd0) begin
      fails++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", pkt_gen_cnt, pkt_drop_cnt);
    end
    in_rd_alf = 1'b1; in_rd_phv_alf = 1'b0; #1;
    comps++;
    if (out_rd_alf !== 1'b1 || out_rd_phv_alf !== 1'b0) begin
      fails++; $display("FAIL alf_copy1 got %b%b exp 10", out_rd_alf, out_rd_phv_alf);
    end
    in_rd_alf = 1'b0; in_rd_phv_alf = 1'b1; #1;
    comps++;
    if (out_rd_alf !== 1'b0 || out_rd_phv_alf !== 1'b1) begin
      fails++; $display("FAIL alf_copy2 got %b%b exp 01", out_rd_alf, out_rd_phv_alf);
    end
    in_rd_phv_alf = 1'b0;
    @(negedge clk);
    comps++;
    if (out_rd_data_wr !== 1'b0 || rd2ram_rd_en !== 1'b0) begin
      fails++; $display("FAIL reset_quiet got %b%b exp 00", out_rd_data_wr, rd2ram_rd_en);
    end
  endtask

  // Sequence 0: clean head/body/tail. Sequence 1: a second head arrives before the tail.
  task automatic test_pass();
    logic [133:0]  seq [5];
    logic [1023:0] phv;
    int            len;
    for (int s = 0; s < 2; s++) begin
      apply_reset();
      phv = '0;
      phv[63:0] = 64'hFEED_FACE_0123_4567 + 64'(s);
      if (s == 0) begin
        len = 3;
        seq[0] = mk(2'b01, 32'h111); seq[1] = mk(2'b11, 32'h222); seq[2] = mk(2'b10, 32'h333);
      end else begin
        len = 5;
        seq[0] = mk(2'b01, 32'h10); seq[1] = mk(2'b11, 32'h11); seq[2] = mk(2'b01, 32'h20);
        seq[3] = mk(2'b11, 32'h21); seq[4] = mk(2'b10, 32'h22);
      end
      drive_up(1'b1, seq[0], 1'b1, phv);
      for (int n = 1; n <= len + 1; n++) begin
        @(negedge clk);
        if (n <= len) begin
          comps++;
          if (out_rd_data_wr !== 1'b1 || out_rd_valid !== 1'b1 || out_rd_data !== seq[n-1]) begin
            fails++; $display("FAIL pass_beat s=%0d n=%0d got wr=%b d=%h exp wr=1 d=%h", s, n,
                              out_rd_data_wr, out_rd_data, seq[n-1]);
          end
          comps++;
          if (out_rd_valid_wr !== (n == len)) begin
            fails++; $display("FAIL pass_valid_wr s=%0d n=%0d got %b exp %b", s, n,
                              out_rd_valid_wr, (n == len));
          end
          comps++;
          if (out_rd_phv_wr !== (n == 1) || out_rd_phv !== ((n == 1) ? phv : '0)) begin
            fails++; $display("FAIL pass_phv s=%0d n=%0d got wr=%b p=%h exp wr=%b", s, n,
                              out_rd_phv_wr, out_rd_phv[63:0], (n == 1));
          end
        end else begin
          comps++;
          if (out_rd_data_wr !== 1'b0 || out_rd_data !== '0 || out_rd_valid_wr !== 1'b0) begin
            fails++; $display("FAIL pass_after s=%0d got wr=%b d=%h exp 0", s, out_rd_data_wr,
                              out_rd_data);
          end
          comps++;
          if (pkt_drop_cnt !== 32'd0) begin
            fails++; $display("FAIL pass_drop s=%0d got %0d exp 0", s, pkt_drop_cnt);
          end
        end
        if (n < len) drive_up(1'b1, seq[n], 1'b0, '0);
        else         drive_up(1'b0, '0, 1'b0, '0);
      end
    end
  endtask

  // Period of 6 cycles: rd_en for addrs 0..4 (4 is the overshoot), then a one-cycle gap.
  task automatic test_gen_finish();
    int p, ph, idx;
    logic [133:0] ed;
    apply_reset();
    load_pkt4();
    pgm_sent_start_flag = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      p = (n - 1) / 6; ph = (n - 1) % 6;
      idx = ph - 2;
      ed = (ph >= 2) ? mem[idx] : '0;
      comps++;
      if (rd2ram_rd_en !== (ph < 5) || rd2ram_addr !== ((ph < 5) ? 7'(ph) : 7'd0)) begin
        fails++; $display("FAIL gen_rd n=%0d got en=%b a=%0d exp en=%b a=%0d", n, rd2ram_rd_en,
                          rd2ram_addr, (ph < 5), (ph < 5) ? ph : 0);
      end
      comps++;
      if (out_rd_data_wr !== (ph >= 2) || out_rd_data !== ed ||
          out_rd_valid !== (ph >= 2)) begin
        fails++; $display("FAIL gen_data n=%0d got wr=%b d=%h exp wr=%b d=%h", n,
                          out_rd_data_wr, out_rd_data, (ph >= 2), ed);
      end
      comps++;
      if (out_rd_phv_wr !== (ph == 2) || out_rd_phv !== '0 || out_rd_valid_wr !== (ph == 5)) begin
        fails++; $display("FAIL gen_strobe n=%0d got pw=%b vw=%b exp pw=%b vw=%b", n,
                          out_rd_phv_wr, out_rd_valid_wr, (ph == 2), (ph == 5));
      end
      comps++;
      if (pkt_gen_cnt !== 32'((ph == 5) ? p + 1 : p)) begin
        fails++; $display("FAIL gen_cnt n=%0d got %0d exp %0d", n, pkt_gen_cnt,
                          (ph == 5) ? p + 1 : p);
      end
      if (n == 16) pgm_sent_finish_flag = 1'b1;
    end
    for (int n = 19; n <= 24; n++) begin
      @(negedge clk);
      comps++;
      if (rd2ram_rd_en !== 1'b0 || out_rd_data_wr !== 1'b0 || pkt_gen_cnt !== 32'd3) begin
        fails++; $display("FAIL finish_idle n=%0d got en=%b wr=%b cnt=%0d exp 0 0 3", n,
                          rd2ram_rd_en, out_rd_data_wr, pkt_gen_cnt);
      end
    end
  endtask

  task automatic test_wrap();
    logic [133:0] ed;
    logic         een, ewr;
    logic [6:0]   ea;
    apply_reset();
    for (int i = 0; i < 128; i++) mem[i] = mk((i == 0) ? 2'b01 : 2'b11, 32'h5000 + 32'(i));
    pgm_sent_start_flag = 1'b1;
    for (int n = 1; n <= 131; n++) begin
      @(negedge clk);
      een = (n <= 128) || (n == 131);
      ea  = (n <= 128) ? 7'(n - 1) : 7'd0;
      ewr = (n >= 3) && (n <= 130);
      ed  = '0;
      if (ewr) ed = mem[n-3];
      if (n == 130) ed[133:132] = 2'b10;
      comps++;
      if (rd2ram_rd_en !== een || rd2ram_addr !== ea) begin
        fails++; $display("FAIL wrap_rd n=%0d got en=%b a=%0d exp en=%b a=%0d", n,
                          rd2ram_rd_en, rd2ram_addr, een, ea);
      end
      comps++;
      if (out_rd_data_wr !== ewr || out_rd_data !== ed || out_rd_valid_wr !== (n == 130)) begin
        fails++; $display("FAIL wrap_data n=%0d got wr=%b vw=%b d=%h exp wr=%b d=%h", n,
                          out_rd_data_wr, out_rd_valid_wr, out_rd_data, ewr, ed);
      end
      comps++;
      if (pkt_gen_cnt !== ((n >= 130) ? 32'd1 : 32'd0)) begin
        fails++; $display("FAIL wrap_cnt n=%0d got %0d exp %0d", n, pkt_gen_cnt, n >= 130);
      end
    end
  endtask

  // in_rd_alf is high briefly mid-packet (ignored), then for 10 cycles in the gap.
  task automatic test_alf();
    logic       een;
    logic [6:0] ea;
    apply_reset();
    load_pkt4();
    pgm_sent_start_flag = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      een = (n <= 5) || (n >= 17);
      ea  = (n <= 5) ? 7'(n - 1) : ((n >= 17) ? 7'(n - 17) : 7'd0);
      comps++;
      if (rd2ram_rd_en !== een || rd2ram_addr !== ea) begin
        fails++; $display("FAIL alf_rd n=%0d got en=%b a=%0d exp en=%b a=%0d", n,
                          rd2ram_rd_en, rd2ram_addr, een, ea);
      end
      comps++;
      if (pkt_gen_cnt !== ((n >= 6) ? 32'd1 : 32'd0)) begin
        fails++; $display("FAIL alf_cnt n=%0d got %0d exp %0d", n, pkt_gen_cnt, n >= 6);
      end
      in_rd_alf = ((n >= 2) && (n <= 3)) || ((n >= 6) && (n <= 15));
    end
    in_rd_alf = 1'b0;
  endtask

  task automatic test_drop();
    logic       ewr;
    logic [133:0] ed;
    int         edrop;
    apply_reset();
    load_pkt4();
    pgm_sent_start_flag = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      edrop = (n <= 1) ? 0 : ((n == 2) ? 1 : 2);
      ewr = ((n >= 3) && (n <= 6)) || (n >= 11);
      ed  = '0;
      if (n >= 3 && n <= 6) ed = mem[n-3];
      if (n == 11) ed = mk(2'b01, 32'h77);
      if (n == 12) ed = mk(2'b10, 32'h78);
      comps++;
      if (pkt_drop_cnt !== 32'(edrop)) begin
        fails++; $display("FAIL drop_cnt n=%0d got %0d exp %0d", n, pkt_drop_cnt, edrop);
      end
      comps++;
      if (rd2ram_rd_en !== (n <= 5)) begin
        fails++; $display("FAIL drop_rd n=%0d got %b exp %b", n, rd2ram_rd_en, (n <= 5));
      end
      comps++;
      if (out_rd_data_wr !== ewr || out_rd_data !== ed) begin
        fails++; $display("FAIL drop_data n=%0d got wr=%b d=%h exp wr=%b d=%h", n,
                          out_rd_data_wr, out_rd_data, ewr, ed);
      end
      unique case (n)
        1:  begin drive_up(1'b1, mk(2'b01, 32'h61), 1'b0, '0); pgm_sent_start_flag = 1'b0; end
        2:  drive_up(1'b1, mk(2'b11, 32'h62), 1'b0, '0);
        7:  drive_up(1'b1, mk(2'b11, 32'h63), 1'b0, '0);
        8:  drive_up(1'b1, mk(2'b10, 32'h64), 1'b0, '0);
        10: drive_up(1'b1, mk(2'b01, 32'h77), 1'b0, '0);
        11: drive_up(1'b1, mk(2'b10, 32'h78), 1'b0, '0);
        default: drive_up(1'b0, '0, 1'b0, '0);
      endcase
    end
  endtask

  task automatic test_bypass();
    apply_reset();
    pgm_bypass_flag = 1'b1;
    pgm_sent_start_flag = 1'b1;
    drive_up(1'b1, mk(2'b01, 32'h91), 1'b0, '0);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      comps++;
      if (rd2ram_rd_en !== 1'b0 || out_rd_data_wr !== (n <= 2) || out_rd_valid_wr !== (n == 2))
      begin
        fails++; $display("FAIL bypass n=%0d got en=%b wr=%b vw=%b exp 0 %b %b", n,
                          rd2ram_rd_en, out_rd_data_wr, out_rd_valid_wr, (n <= 2), (n == 2));
      end
      if (n == 1) drive_up(1'b1, mk(2'b10, 32'h92), 1'b0, '0);
      else        drive_up(1'b0, '0, 1'b0, '0);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    load_pkt4();
    pgm_sent_start_flag = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) drive_up(1'b1, mk(2'b10, 32'h55), 1'b0, '0);
      else        drive_up(1'b0, '0, 1'b0, '0);
    end
    comps++;
    if (out_rd_data_wr !== 1'b1 || pkt_gen_cnt !== 32'd1 || pkt_drop_cnt !== 32'd1) begin
      fails++; $display("FAIL rstmid_pre got wr=%b gen=%0d drop=%0d exp 1 1 1", out_rd_data_wr,
                        pkt_gen_cnt, pkt_drop_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    comps++;
    if ({rd2ram_rd_en, rd2ram_addr, out_rd_data_wr, out_rd_valid, out_rd_phv_wr} !== 11'd0 ||
        out_rd_data !== '0) begin
      fails++; $display("FAIL rstmid_out got en=%b a=%0d wr=%b d=%h exp 0", rd2ram_rd_en,
                        rd2ram_addr, out_rd_data_wr, out_rd_data);
    end
    comps++;
    if (pkt_gen_cnt !== 32'd0 || pkt_drop_cnt !== 32'd0) begin
      fails++; $display("FAIL rstmid_cnt got %0d/%0d exp 0/0", pkt_gen_cnt, pkt_drop_cnt);
    end
    pgm_sent_start_flag = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      comps++;
      if (rd2ram_rd_en !== 1'b0 || out_rd_data_wr !== 1'b0 || out_rd_data !== '0) begin
        fails++; $display("FAIL rstmid_idle n=%0d got en=%b wr=%b exp 0 0", n, rd2ram_rd_en,
                          out_rd_data_wr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_gen_finish();
    test_wrap();
    test_alf();
    test_drop();
    test_bypass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule
